// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, sequencer states and default sizes.
package alu_pkg;

  localparam int WIDTH_DEF = 64;
  localparam int SLICE_DEF = 16;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  function automatic logic op_is_legal(input logic [1:0] op);
    return op != OP_ILL;
  endfunction

endpackage

// File: rtl/logic_slice.sv
// One slice of the bitwise logic datapath; shared across all slices of an operation.
module logic_slice #(
  parameter int SLICE = alu_pkg::SLICE_DEF
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic [1:0]       op,
  output logic [SLICE-1:0] y
);
  import alu_pkg::*;

  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/logic_seq_unit.sv
// Multi-cycle bitwise logic engine: evaluates one SLICE-bit slice per cycle
// through a single logic_slice, with valid/ready handshakes on both sides.
module logic_seq_unit #(
  parameter int WIDTH = alu_pkg::WIDTH_DEF,
  parameter int SLICE = alu_pkg::SLICE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             err
);
  import alu_pkg::*;

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NSLICE - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [1:0]       op_reg;

  logic [SLICE-1:0] a_slice;
  logic [SLICE-1:0] b_slice;
  logic [SLICE-1:0] y_slice;
  logic [WIDTH-1:0] result_next;

  always_comb begin
    a_slice = '0;
    b_slice = '0;
    for (int i = 0; i < NSLICE; i++) begin
      if (cnt == CNT_W'(i)) begin
        a_slice = a_reg[i*SLICE +: SLICE];
        b_slice = b_reg[i*SLICE +: SLICE];
      end
    end
  end

  logic_slice #(
    .SLICE (SLICE)
  ) u_slice (
    .a  (a_slice),
    .b  (b_slice),
    .op (op_reg),
    .y  (y_slice)
  );

  // Kept in a separate block from the operand mux so the slice path is not a
  // false combinational loop through one process.
  always_comb begin
    result_next = result;
    for (int i = 0; i < NSLICE; i++) begin
      if (cnt == CNT_W'(i)) begin
        result_next[i*SLICE +: SLICE] = y_slice;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      op_reg    <= OP_AND;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_reg    <= a;
            b_reg    <= b;
            op_reg   <= op;
            cnt      <= '0;
            result   <= '0;
            in_ready <= 1'b0;
            if (op_is_legal(op)) begin
              state <= BUSY;
              zero  <= 1'b0;
              err   <= 1'b0;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
              zero      <= 1'b1;
              err       <= 1'b1;
            end
          end
        end

        // Zero is taken from result_next so the final slice is included.
        BUSY: begin
          result <= result_next;
          if (cnt == LAST_SLICE) begin
            state     <= DONE;
            out_valid <= 1'b1;
            zero      <= ~|result_next;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logic_seq_unit.sv
// Directed self-checking bench for logic_seq_unit at default parameters.
module tb_logic_seq_unit;

  localparam logic [1:0] T_AND = 2'b00;
  localparam logic [1:0] T_OR  = 2'b01;
  localparam logic [1:0] T_XOR = 2'b10;
  localparam logic [1:0] T_ILL = 2'b11;

  localparam logic [63:0] VA = 64'hFFFF_0000_AAAA_5555;
  localparam logic [63:0] VB = 64'h0F0F_F0F0_FFFF_0000;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [63:0] a;
  logic [63:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        zero;
  logic        err;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  logic_seq_unit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .err       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Presents a request and returns once it has been accepted; in_valid stays high.
  task automatic applyStimulus(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y,
                               output int acc_cyc);
    int k;
    op = o;
    a = x;
    b = y;
    in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 50) begin
      stepCycle();
      k++;
    end
    if (!in_ready) checkOutput("accept_timeout", 64'd0, 64'd1);
    stepCycle();
    acc_cyc = cyc;
  endtask

  task automatic waitResult(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      stepCycle();
      lat++;
    end
    if (!out_valid) checkOutput("result_timeout", 64'd0, 64'd1);
  endtask

  task automatic runOp(input string tag, input logic [1:0] o, input logic [63:0] x,
                       input logic [63:0] y, input logic [63:0] exp_res, input logic exp_zero,
                       input logic exp_err, input int exp_lat);
    int acc;
    int lat;
    out_ready = 1'b1;
    applyStimulus(o, x, y, acc);
    in_valid = 1'b0;
    waitResult(lat);
    checkOutput({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    checkOutput({tag, "_result"}, result, exp_res);
    checkOutput({tag, "_zero"}, 64'(zero), 64'(exp_zero));
    checkOutput({tag, "_err"}, 64'(err), 64'(exp_err));
    checkOutput({tag, "_inrdy_busy"}, 64'(in_ready), 64'd0);
    stepCycle();
    checkOutput({tag, "_ovalid_drop"}, 64'(out_valid), 64'd0);
    checkOutput({tag, "_inrdy_idle"}, 64'(in_ready), 64'd1);
    checkOutput({tag, "_hold"}, result, exp_res);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, tests_failed %0d", tests_failed);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc;
    int lat;
    logic [1:0]  bop  [3];
    logic [63:0] ba   [3];
    logic [63:0] bb   [3];
    logic [63:0] bexp [3];
    int          bacc [3];

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    op = 2'b00;
    a = '0;
    b = '0;

    #2;
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_result", result, 64'd0);
    checkOutput("rst_zero", 64'(zero), 64'd0);
    checkOutput("rst_err", 64'(err), 64'd0);
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    stepCycle();

    runOp("and", T_AND, VA, VB, 64'h0F0F_0000_AAAA_0000, 1'b0, 1'b0, 4);
    runOp("or",  T_OR,  VA, VB, 64'hFFFF_F0F0_FFFF_5555, 1'b0, 1'b0, 4);
    runOp("xor", T_XOR, VA, VB, 64'hF0F0_F0F0_5555_5555, 1'b0, 1'b0, 4);
    runOp("zero", T_XOR, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 64'd0, 1'b1, 1'b0, 4);
    runOp("ill", T_ILL, VA, VB, 64'd0, 1'b1, 1'b1, 0);

    // Abort after two slices have been written.
    out_ready = 1'b1;
    applyStimulus(T_AND, VA, VB, acc);
    in_valid = 1'b0;
    stepCycle();
    stepCycle();
    checkOutput("midbusy_partial", result, 64'h0000_0000_AAAA_0000);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("midrst_result", result, 64'd0);
    checkOutput("midrst_zero", 64'(zero), 64'd0);
    checkOutput("midrst_err", 64'(err), 64'd0);
    #1 rst = 1'b0;
    stepCycle();
    runOp("postrst", T_OR, 64'h8000_0000_0000_0001, 64'h0000_0001_0000_0000,
          64'h8000_0001_0000_0001, 1'b0, 1'b0, 4);

    // Backpressure with a new request waiting.
    out_ready = 1'b0;
    applyStimulus(T_OR, VA, VB, acc);
    op = T_XOR;
    a = 64'h00FF_00FF_00FF_00FF;
    b = 64'hFFFF_0000_FFFF_0000;
    waitResult(lat);
    checkOutput("bp_lat", 64'(lat), 64'd4);
    for (int i = 0; i < 10; i++) begin
      checkOutput("bp_result", result, 64'hFFFF_F0F0_FFFF_5555);
      checkOutput("bp_zero", 64'(zero), 64'd0);
      checkOutput("bp_err", 64'(err), 64'd0);
      checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
      checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
      stepCycle();
    end
    out_ready = 1'b1;
    stepCycle();
    out_ready = 1'b0;
    checkOutput("bp_idle_in_ready", 64'(in_ready), 64'd1);
    checkOutput("bp_idle_out_valid", 64'(out_valid), 64'd0);
    stepCycle();
    in_valid = 1'b0;
    checkOutput("bp_accepted", 64'(in_ready), 64'd0);
    waitResult(lat);
    checkOutput("bp2_lat", 64'(lat), 64'd4);
    checkOutput("bp2_result", result, 64'hFF00_00FF_FF00_00FF);
    checkOutput("bp2_zero", 64'(zero), 64'd0);
    checkOutput("bp2_err", 64'(err), 64'd0);
    out_ready = 1'b1;
    stepCycle();

    // Three requests queued back to back.
    bop[0] = T_AND; ba[0] = VA; bb[0] = VB; bexp[0] = 64'h0F0F_0000_AAAA_0000;
    bop[1] = T_OR;  ba[1] = VA; bb[1] = VB; bexp[1] = 64'hFFFF_F0F0_FFFF_5555;
    bop[2] = T_OR;  ba[2] = 64'hABCD_0000_0000_0000; bb[2] = 64'd0;
    bexp[2] = 64'hABCD_0000_0000_0000;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(bop[i], ba[i], bb[i], bacc[i]);
      waitResult(lat);
      checkOutput("b2b_lat", 64'(lat), 64'd4);
      checkOutput("b2b_result", result, bexp[i]);
      checkOutput("b2b_zero", 64'(zero), 64'd0);
    end
    in_valid = 1'b0;
    checkOutput("b2b_gap01", 64'(bacc[1] - bacc[0]), 64'd6);
    checkOutput("b2b_gap12", 64'(bacc[2] - bacc[1]), 64'd6);
    stepCycle();
    checkOutput("b2b_final_idle", 64'(in_ready), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/logic_seq_unit.md
Name: logic_seq_unit

Overview:
- Sequential bitwise logic engine for the ALU: accepts a request (opcode plus two WIDTH-bit operands) over a valid/ready handshake.
- Evaluates the operation one SLICE-bit slice per cycle, reusing a single slice datapath.
- Returns the result, a zero flag and an illegal-opcode flag over a second valid/ready handshake.
- Serves as the multi-cycle, area-reduced counterpart of the flat 64-bit gate library, driven by the execute stage.

Parameters:
- WIDTH, 64, operand/result width in bits; must be an integer multiple of SLICE.
- SLICE, 16, bits evaluated per cycle; NSLICE = WIDTH/SLICE.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  request present.
- in_ready  output  1  unit can accept a request.
- op  input  2  00 AND, 01 OR, 10 XOR, 11 illegal.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- result  output  WIDTH  operation result.
- zero  output  1  result == 0.
- err  output  1  op was illegal.

Behaviour:
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0, result=0, zero=0, err=0, slice counter=0.
  - All internal operand/op registers cleared.
  - Reset mid-operation aborts immediately; no partial result is ever presented.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, capture a, b and op; clear the result register; go to BUSY with cnt=0. If op==11, go directly to DONE instead, with result=0, err=1, zero=1.
  - BUSY: in_ready=0. Each cycle, write result[cnt*SLICE +: SLICE] = a_slice OP b_slice, then cnt++. After the slice at cnt==NSLICE-1, go to DONE and compute zero from the full result.
  - DONE: out_valid=1; result, zero and err are stable and held until out_valid&&out_ready. On that handshake go to IDLE; out_valid drops the next cycle.
- Latency, legal op:
  - Accept edge T0.
  - Slices written at edges T1..T_NSLICE (4 edges at default).
  - out_valid high from T_NSLICE+1 cycle onwards, i.e. the cycle after the last slice write.
  - Default: out_valid visible in cycle 5 after acceptance, with out_ready=1 throughout.
- Latency, illegal op: out_valid asserted the cycle after acceptance.
- Throughput: one request in flight. in_ready is low in BUSY and DONE; a new request is accepted only in IDLE, the cycle after the output handshake.
- Handshake:
  - in_valid may be held high across busy cycles; the unit does not sample it until IDLE.
  - Operand changes while not accepted are ignored.
  - out_ready is a don't-care outside DONE.
  - out_valid, once high, is never withdrawn without a handshake.
- Arithmetic: pure bitwise, with no carry or inter-slice dependency. The zero flag is a WIDTH-wide NOR of the final result register, registered at entry to DONE.
- Counter: width clog2(NSLICE), minimum 1 bit. Reset to 0 on every accept and never wraps mid-operation.
- result, zero and err change only on accept (clear), in BUSY (slice writes), on entry to DONE, and on reset. After the output handshake they hold their last value until the next accept.

Decomposition:
- Shared package alu_pkg:
  - opcode constants OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_ILL=2'b11.
  - state encoding IDLE/BUSY/DONE.
  - default WIDTH and SLICE constants.
- One sub-module: logic_slice. Combinational; SLICE-bit a, b and op in, SLICE-bit y out. The top instantiates it once and muxes the operand slices by cnt.

Test Plan:
- Reset: assert rst asynchronously mid-BUSY (op=AND after 2 slices) -> same-cycle in_ready=1, out_valid=0, result=0; a fresh request afterwards completes correctly.
- AND/OR/XOR: a=64'hFFFF_0000_AAAA_5555, b=64'h0F0F_F0F0_FFFF_0000, out_ready=1 -> out_valid in 5th cycle after accept.
  - AND gives 64'h0F0F_0000_AAAA_0000.
  - OR gives 64'hFFFF_F0F0_FFFF_5555.
  - XOR gives 64'hF0F0_F0F0_5555_5555.
  - zero=0, err=0 in all three cases.
- Zero flag: op=XOR, a=b=64'h1234_5678_9ABC_DEF0 -> result=0, zero=1, err=0.
- Illegal op: op=11 -> out_valid the cycle after accept, result=0, zero=1, err=1; no BUSY cycles.
- Backpressure: out_ready=0 for 10 cycles after out_valid rises, with in_valid held high and new operands presented -> result, zero and err are stable, in_ready=0 throughout, no new accept; accept occurs the cycle after out_ready pulses high.
- Back-to-back: 3 queued requests with in_valid and out_ready held high -> accepts spaced exactly 6 cycles apart at default parameters, results in order.
